// File: rtl/mul64_issue_ctrl.sv
// Issue controller for the pipelined 64x64 multiplier wrapper: one op in flight,
// ce/a/b held until the valid strobe, product returned over valid/ready with a timeout watchdog.
module mul64_issue_ctrl #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 18,
    parameter int unsigned TIMEOUT = LATENCY + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             mul_ce,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic             mul_valid,
    input  logic [WIDTH-1:0] mul_p,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_p,
    output logic             resp_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mul_ce_nxt;
    logic [WIDTH-1:0]   mul_a_nxt, mul_b_nxt;
    logic               resp_valid_nxt;
    logic [WIDTH-1:0]   resp_p_nxt;
    logic               resp_err_nxt;

    // Only combinational output; masked during reset so nothing is accepted then.
    assign req_ready = (state == ST_IDLE) & ~rst;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mul_ce     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_valid <= 1'b0;
            resp_p     <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mul_ce     <= mul_ce_nxt;
            mul_a      <= mul_a_nxt;
            mul_b      <= mul_b_nxt;
            resp_valid <= resp_valid_nxt;
            resp_p     <= resp_p_nxt;
            resp_err   <= resp_err_nxt;
        end
    end

    // Next-state and output logic; mul_valid/mul_p are only looked at in BUSY.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mul_ce_nxt     = mul_ce;
        mul_a_nxt      = mul_a;
        mul_b_nxt      = mul_b;
        resp_valid_nxt = resp_valid;
        resp_p_nxt     = resp_p;
        resp_err_nxt   = resp_err;

        unique case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    mul_a_nxt  = req_a;
                    mul_b_nxt  = req_b;
                    mul_ce_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt + CNT_W'(1);
                // A real strobe takes priority over a coincident timeout.
                if (mul_valid) begin
                    resp_p_nxt     = mul_p;
                    resp_err_nxt   = 1'b0;
                    resp_valid_nxt = 1'b1;
                    mul_ce_nxt     = 1'b0;
                    state_nxt      = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_p_nxt     = '0;
                    resp_err_nxt   = 1'b1;
                    resp_valid_nxt = 1'b1;
                    mul_ce_nxt     = 1'b0;
                    state_nxt      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul64_issue_ctrl.sv
// Bench for mul64_issue_ctrl: CE-gated stub wrapper plus a transaction-level reference
// (product = a*b truncated, fixed response latency, timeout abort).
module tb_mul64_issue_ctrl;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned LATENCY = 18;
    localparam int unsigned TIMEOUT = LATENCY + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a, req_b;
    logic             mul_ce;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_valid;
    logic [WIDTH-1:0] mul_p;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_p;
    logic             resp_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mul64_issue_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_ce     (mul_ce),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_valid  (mul_valid),
        .mul_p      (mul_p),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .resp_err   (resp_err)
    );

    // Stub wrapper: valid/product chain advances on ce, any ce-low cycle flushes it.
    logic [LATENCY-1:0] vchain;
    logic [WIDTH-1:0]   pchain [LATENCY];
    logic               stub_mute;
    logic               force_valid;

    always @(posedge clk) begin
        if (!mul_ce) begin
            vchain <= '0;
        end else begin
            vchain    <= {vchain[LATENCY-2:0], 1'b1};
            pchain[0] <= mul_a * mul_b;
            for (int i = 1; i < LATENCY; i++) pchain[i] <= pchain[i-1];
        end
    end

    assign mul_valid = (vchain[LATENCY-1] & ~stub_mute) | force_valid;
    assign mul_p     = force_valid ? 64'hBAD0_BAD0_BAD0_BAD0 : pchain[LATENCY-1];

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One full transaction against the reference: accept, hold, respond, drain.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit mute, input int hold, input bit poke_done);
        int               cyc;
        bit               ok;
        logic [WIDTH-1:0] exp_p;
        int               exp_lat;
        exp_p   = mute ? '0 : a * b;
        exp_lat = mute ? int'(TIMEOUT) : int'(LATENCY + 1);
        stub_mute = mute;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        ok  = 1'b1;
        cyc = 0;
        while (!resp_valid && cyc < 60) begin
            if (!(mul_ce && mul_a == a && mul_b == b && !req_ready)) ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("busy_hold", 64'(ok), 64'(1));
        check("latency", 64'(cyc), 64'(exp_lat));
        check("resp_p", resp_p, exp_p);
        check("resp_err", 64'(resp_err), 64'(mute));
        check("done_ce_low", 64'(mul_ce), 64'(0));
        stub_mute = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            force_valid = poke_done && (i == 0);
            @(negedge clk);
            force_valid = 1'b0;
            if (!(resp_valid && resp_p == exp_p && resp_err == mute && !req_ready && !mul_ce)) ok = 1'b0;
        end
        if (hold > 0) check("done_hold", 64'(ok), 64'(1));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("drain_valid", 64'(resp_valid), 64'(0));
        check("drain_ready", 64'(req_ready), 64'(1));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int               cyc;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_a       = '0;
        req_b       = '0;
        resp_ready  = 1'b0;
        stub_mute   = 1'b0;
        force_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mul_ce", 64'(mul_ce), 64'(0));
        check("rst_mul_a", mul_a, '0);
        check("rst_mul_b", mul_b, '0);
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_p", resp_p, '0);
        check("rst_resp_err", 64'(resp_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'(1));

        run_op(64'd3, 64'd5, 1'b0, 0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 0, 1'b0);
        run_op(64'd0, 64'hDEAD, 1'b0, 0, 1'b0);
        run_op(64'd11, 64'd13, 1'b0, 10, 1'b0);
        run_op(64'd9, 64'd9, 1'b1, 3, 1'b0);

        // Abandon an op mid-flight with a reset pulse.
        req_valid = 1'b1;
        req_a     = 64'd100;
        req_b     = 64'd200;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ce", 64'(mul_ce), 64'(0));
        check("midrst_mul_a", mul_a, '0);
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid) cyc++;
            @(negedge clk);
        end
        check("midrst_no_resp", 64'(cyc), 64'(0));
        run_op(64'd7, 64'd6, 1'b0, 0, 1'b0);

        // Stray strobe while idle must be ignored.
        force_valid = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        @(negedge clk);
        check("idle_poke_valid", 64'(resp_valid), 64'(0));
        check("idle_poke_ce", 64'(mul_ce), 64'(0));
        check("idle_poke_ready", 64'(req_ready), 64'(1));

        for (int n = 0; n < 16; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n == 3) ra = '1;
            if (n == 4) rb = '0;
            run_op(ra, rb, 1'b0, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
